// File: rtl/miner_ctrl_regs.sv
// AXI-Lite control/status registers for the multi-core miner: block header, nonce
// partitioning, start/flush control and a result FIFO fed by per-core pending slots.
module miner_ctrl_regs #(
    parameter int CORES      = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk_main_a0,
    input  logic                  rst_main,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           awaddr,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [31:0]           araddr,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic [639:0]          block,
    output logic [CORES-1:0]      core_start,
    output logic [32*CORES-1:0]   core_nonce_start,
    input  logic [CORES-1:0]      core_found,
    input  logic [32*CORES-1:0]   core_nonce
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] A_BLK0   = 32'h504;
    localparam logic [31:0] A_BLKN   = 32'h550;
    localparam logic [31:0] A_RESULT = 32'h554;
    localparam logic [31:0] A_STATUS = 32'h558;
    localparam logic [31:0] A_BASE   = 32'h55C;
    localparam logic [31:0] A_CTRL   = 32'h560;
    localparam logic [31:0] A_FCNT   = 32'h564;

    logic              wr_active, arvalid_q, start_q, clr_q;
    logic [31:0]       wr_addr, rd_addr, rd_val, nonce_base, found_count;
    logic [19:0][31:0] blk_words;
    logic              wr_is_blk, rd_is_blk, start_hit, flush_hit, clr;
    logic [4:0]        wr_slot, rd_slot;
    logic [CORES-1:0]  slot_vld, push_sel;
    logic [CORES-1:0][31:0] slot_nonce;
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     fifo_cnt;
    logic              fifo_full, fifo_empty, overflow;
    logic              push_any, push, pop;
    logic [31:0]       push_data;
    logic              unused_wstrb;

    assign unused_wstrb = ^wstrb;
    assign bresp   = 2'b00;
    assign rresp   = 2'b00;
    assign awready = !wr_active;
    assign wready  = wr_active && wvalid && !bvalid;
    assign arready = !arvalid_q && !rvalid;
    assign block   = blk_words;
    assign core_start = {CORES{start_q}};

    // Header word at 0x504 is the top of the 640-bit vector, so packed index = 20 - addr[6:2].
    assign wr_is_blk = (wr_addr >= A_BLK0) && (wr_addr <= A_BLKN) && (wr_addr[1:0] == 2'b00);
    assign rd_is_blk = (rd_addr >= A_BLK0) && (rd_addr <= A_BLKN) && (rd_addr[1:0] == 2'b00);
    assign wr_slot   = 5'd20 - wr_addr[6:2];
    assign rd_slot   = 5'd20 - rd_addr[6:2];
    assign start_hit = wready && (wr_addr == A_BLKN);
    assign flush_hit = wready && (wr_addr == A_CTRL) && wdata[0];
    assign clr       = start_hit || flush_hit;

    genvar g;
    generate
        for (g = 0; g < CORES; g++) begin : g_part
            localparam logic [63:0] OFFS = (64'h1_0000_0000 / CORES) * g;
            assign core_nonce_start[32*g +: 32] = nonce_base + OFFS[31:0];
        end
    endgenerate

    assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);

    // Descending scan so the lowest-index valid slot wins.
    always_comb begin
        push_any  = 1'b0;
        push_data = '0;
        push_sel  = '0;
        for (int i = CORES - 1; i >= 0; i--) begin
            if (slot_vld[i]) begin
                push_any  = 1'b1;
                push_data = slot_nonce[i];
                push_sel  = CORES'(1) << i;
            end
        end
    end

    assign push = push_any && !fifo_full;
    assign pop  = arvalid_q && (rd_addr == A_RESULT) && !fifo_empty;

    always_comb begin
        rd_val = 32'hFFFF_FFFF;
        if (rd_is_blk) begin
            rd_val = blk_words[rd_slot];
        end else begin
            case (rd_addr)
                A_RESULT: rd_val = fifo_empty ? 32'h0 : fifo_mem[rd_ptr];
                A_STATUS: rd_val = {8'h00, 8'(CORES), 8'(fifo_cnt), 4'h0,
                                    |slot_vld, overflow, fifo_full, fifo_empty};
                A_BASE:   rd_val = nonce_base;
                A_CTRL:   rd_val = 32'h0;
                A_FCNT:   rd_val = found_count;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            wr_active  <= 1'b0;
            wr_addr    <= '0;
            bvalid     <= 1'b0;
            arvalid_q  <= 1'b0;
            rd_addr    <= '0;
            rvalid     <= 1'b0;
            rdata      <= '0;
            blk_words  <= '0;
            nonce_base <= '0;
            start_q    <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            start_q <= start_hit;
            clr_q   <= clr;
            if (awvalid && awready) begin
                wr_active <= 1'b1;
                wr_addr   <= awaddr;
            end
            if (wready) begin
                bvalid <= 1'b1;
                if (wr_is_blk) blk_words[wr_slot] <= wdata;
                if (wr_addr == A_BASE) nonce_base <= wdata;
            end
            if (bvalid && bready) begin
                bvalid    <= 1'b0;
                wr_active <= 1'b0;
            end
            arvalid_q <= arvalid && arready;
            if (arvalid && arready) rd_addr <= araddr;
            if (arvalid_q) begin
                rvalid <= 1'b1;
                rdata  <= rd_val;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
                rdata  <= '0;
            end
        end
    end

    // Founds arriving while the start/flush pulse is high belong to the old job and are dropped.
    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            slot_vld    <= '0;
            slot_nonce  <= '0;
            overflow    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            found_count <= '0;
        end else if (clr) begin
            slot_vld    <= '0;
            overflow    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            found_count <= '0;
        end else begin
            for (int i = 0; i < CORES; i++) begin
                if (core_found[i] && !clr_q) begin
                    if (slot_vld[i] && !(push && push_sel[i])) begin
                        overflow <= 1'b1;
                    end else begin
                        slot_vld[i]   <= 1'b1;
                        slot_nonce[i] <= core_nonce[32*i +: 32];
                    end
                end else if (push && push_sel[i]) begin
                    slot_vld[i] <= 1'b0;
                end
            end
            if (push) begin
                wr_ptr      <= wr_ptr + AW'(1);
                found_count <= found_count + 32'd1;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_main_a0) begin
        if (push && !clr) fifo_mem[wr_ptr] <= push_data;
    end
endmodule

// File: tb/tb_miner_ctrl_regs.sv
// Bench for miner_ctrl_regs: directed scenarios plus random founds/reads/writes,
// checked against a queue-based model of the register map and result path.
module tb_miner_ctrl_regs;
    localparam int CORES = 4;
    localparam int DEPTH = 16;

    logic clk_main_a0 = 1'b0;
    logic rst_main;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [639:0] block;
    logic [CORES-1:0] core_start, core_found;
    logic [32*CORES-1:0] core_nonce_start, core_nonce;

    int n_cmp = 0;
    int n_err = 0;
    int n_start_pulses = 0;

    // behavioural model state
    logic [31:0] mq[$];
    bit          msv[CORES];
    logic [31:0] msn[CORES];
    logic [31:0] mwords[20];
    logic [31:0] mbase, mfcnt, m_rd_exp, m_rd_addr, m_wr_addr, m_wr_data;
    bit          movf, m_rd_req, m_wr_req, m_core_start, m_clr_prev;

    miner_ctrl_regs #(.CORES(CORES), .FIFO_DEPTH(DEPTH)) dut (
        .clk_main_a0(clk_main_a0), .rst_main(rst_main),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .block(block), .core_start(core_start), .core_nonce_start(core_nonce_start),
        .core_found(core_found), .core_nonce(core_nonce)
    );

    always #5 clk_main_a0 = ~clk_main_a0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        bit pend = 0;
        for (int i = 0; i < CORES; i++) pend |= msv[i];
        return {8'h00, 8'(CORES), 8'(mq.size()), 4'h0, pend, movf,
                mq.size() == DEPTH, mq.size() == 0};
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a >= 32'h504 && a <= 32'h550 && a[1:0] == 2'b00) return mwords[int'((a - 32'h504) >> 2)];
        case (a)
            32'h554: return (mq.size() != 0) ? mq[0] : 32'h0;
            32'h558: return model_status();
            32'h55C: return mbase;
            32'h560: return 32'h0;
            32'h564: return mfcnt;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [639:0] model_block();
        logic [639:0] b;
        for (int k = 0; k < 20; k++) b[639 - 32*k -: 32] = mwords[k];
        return b;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < CORES; i++) begin msv[i] = 0; msn[i] = '0; end
        for (int k = 0; k < 20; k++) mwords[k] = '0;
        mbase = '0; mfcnt = '0; movf = 0;
        m_rd_req = 0; m_wr_req = 0; m_core_start = 0; m_clr_prev = 0;
    endtask

    // One clock of the model: bus events, then FIFO drain, then capture of new founds.
    task automatic model_tick();
        int pre_sz, pidx;
        bit do_pop, clr_now, mask;
        mask = m_clr_prev; clr_now = 0; do_pop = 0; m_core_start = 0;
        pre_sz = mq.size();
        if (m_rd_req) begin
            m_rd_exp = model_read(m_rd_addr);
            do_pop = (m_rd_addr == 32'h554) && (pre_sz != 0);
            m_rd_req = 0;
        end
        if (m_wr_req) begin
            m_wr_req = 0;
            if (m_wr_addr >= 32'h504 && m_wr_addr <= 32'h550 && m_wr_addr[1:0] == 2'b00)
                mwords[int'((m_wr_addr - 32'h504) >> 2)] = m_wr_data;
            if (m_wr_addr == 32'h55C) mbase = m_wr_data;
            if (m_wr_addr == 32'h550) begin clr_now = 1; m_core_start = 1; end
            if (m_wr_addr == 32'h560 && m_wr_data[0]) clr_now = 1;
        end
        if (clr_now) begin
            mq.delete();
            for (int i = 0; i < CORES; i++) msv[i] = 0;
            movf = 0; mfcnt = '0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            pidx = -1;
            for (int i = 0; i < CORES; i++) if (msv[i] && pidx < 0) pidx = i;
            if (pidx >= 0 && pre_sz < DEPTH) begin
                mq.push_back(msn[pidx]); msv[pidx] = 0; mfcnt = mfcnt + 1;
            end
            if (!mask)
                for (int i = 0; i < CORES; i++)
                    if (core_found[i]) begin
                        if (msv[i]) movf = 1;
                        else begin msv[i] = 1; msn[i] = core_nonce[32*i +: 32]; end
                    end
        end
        m_clr_prev = clr_now;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_main_a0 or posedge rst_main);
            if (rst_main) model_reset();
            else model_tick();
        end
    end

    // Per-cycle comparison of the always-meaningful outputs.
    initial begin
        logic [63:0] off;
        forever begin
            @(negedge clk_main_a0);
            #1;
            if (core_start[0] === 1'b1) n_start_pulses++;
            chk("core_start", 32'(core_start), m_core_start ? 32'(CORES'('1)) : 32'h0);
            for (int i = 0; i < CORES; i++) begin
                off = (64'h1_0000_0000 / CORES) * i;
                chk("nonce_start", core_nonce_start[32*i +: 32], mbase + off[31:0]);
            end
            n_cmp++;
            if (block !== model_block()) begin
                n_err++;
                $display("FAIL block: got %h expected %h", block, model_block());
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        int n;
        @(negedge clk_main_a0);
        awvalid = 1; awaddr = a; wvalid = 1; wdata = d;
        n = 0;
        while (!awready && n < 10) begin @(negedge clk_main_a0); n++; end
        if (!awready) chk("wr_awready_timeout", 32'(awready), 32'h1);
        @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        awvalid = 0;
        n = 0;
        while (!wready && n < 10) begin @(negedge clk_main_a0); n++; end
        if (!wready) chk("wr_wready_timeout", 32'(wready), 32'h1);
        m_wr_addr = a; m_wr_data = d; m_wr_req = 1;
        @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        wvalid = 0;
        n = 0;
        while (!bvalid && n < 10) begin @(negedge clk_main_a0); n++; end
        chk("wr_bvalid", 32'(bvalid), 32'h1);
        chk("wr_bresp", 32'(bresp), 32'h0);
        bready = 1;
        @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        bready = 0;
    endtask

    task automatic rd(input logic [31:0] a, input string nm, output logic [31:0] d);
        int n;
        @(negedge clk_main_a0);
        arvalid = 1; araddr = a;
        n = 0;
        while (!arready && n < 10) begin @(negedge clk_main_a0); n++; end
        if (!arready) chk("rd_arready_timeout", 32'(arready), 32'h1);
        @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        arvalid = 0;
        m_rd_addr = a; m_rd_req = 1;
        @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        chk({nm, "_rvalid"}, 32'(rvalid), 32'h1);
        d = rdata;
        chk(nm, rdata, m_rd_exp);
        rready = 1;
        @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        rready = 0;
        chk({nm, "_rdata_clr"}, rdata, 32'h0);
    endtask

    task automatic found_one(input int i, input logic [31:0] n);
        @(negedge clk_main_a0);
        core_found = '0; core_found[i] = 1'b1;
        core_nonce[32*i +: 32] = n;
        @(negedge clk_main_a0);
        core_found = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int unsigned r;
        int p0;
        rst_main = 1; awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0; wstrb = 4'hF;
        bready = 0; arvalid = 0; araddr = '0; rready = 0; core_found = '0; core_nonce = '0;
        repeat (3) @(negedge clk_main_a0);
        chk("rst_awready", 32'(awready), 32'h1);
        chk("rst_arready", 32'(arready), 32'h1);
        chk("rst_wready", 32'(wready), 32'h0);
        chk("rst_bvalid", 32'(bvalid), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_resp", {28'h0, bresp, rresp}, 32'h0);
        rst_main = 0;
        @(negedge clk_main_a0);

        rd(32'h558, "status_reset", d);  chk("status_reset_lit", d, 32'h0004_0001);
        rd(32'h570, "unmapped", d);      chk("unmapped_lit", d, 32'hFFFF_FFFF);

        p0 = n_start_pulses;
        wr(32'h55C, 32'h10);
        for (int k = 0; k < 20; k++) wr(32'h504 + 32'(4*k), 32'(k + 1));
        repeat (3) @(negedge clk_main_a0);
        chk("start_pulse_count", 32'(n_start_pulses - p0), 32'h1);
        chk("block_top_lit", block[639:608], 32'h1);
        chk("block_bot_lit", block[31:0], 32'h14);
        chk("nonce0_lit", core_nonce_start[31:0], 32'h0000_0010);
        chk("nonce1_lit", core_nonce_start[63:32], 32'h4000_0010);
        chk("nonce2_lit", core_nonce_start[95:64], 32'h8000_0010);
        chk("nonce3_lit", core_nonce_start[127:96], 32'hC000_0010);
        rd(32'h504, "blk_word0", d);     chk("blk_word0_lit", d, 32'h1);
        rd(32'h55C, "nonce_base", d);    chk("nonce_base_lit", d, 32'h10);

        @(negedge clk_main_a0);
        core_found = 4'b1101;
        core_nonce = {32'hA3, 32'hA2, 32'h0, 32'hA0};
        @(negedge clk_main_a0);
        core_found = '0;
        repeat (4) @(negedge clk_main_a0);
        rd(32'h554, "res0", d); chk("res0_lit", d, 32'hA0);
        rd(32'h554, "res1", d); chk("res1_lit", d, 32'hA2);
        rd(32'h554, "res2", d); chk("res2_lit", d, 32'hA3);
        rd(32'h554, "res3", d); chk("res_empty_lit", d, 32'h0);
        rd(32'h564, "fcnt", d); chk("fcnt_lit", d, 32'h3);

        p0 = n_start_pulses;
        wr(32'h560, 32'h1);
        rd(32'h558, "status_flush", d); chk("status_flush_lit", d, 32'h0004_0001);
        rd(32'h564, "fcnt_flush", d);   chk("fcnt_flush_lit", d, 32'h0);
        chk("flush_no_pulse", 32'(n_start_pulses - p0), 32'h0);

        for (int k = 0; k < 16; k++) begin
            found_one(1, 32'hB00 + 32'(k));
            repeat (2) @(negedge clk_main_a0);
        end
        found_one(1, 32'hB10);
        repeat (3) @(negedge clk_main_a0);
        rd(32'h558, "status_pend", d); chk("status_pend_lit", d, 32'h0004_100A);
        found_one(1, 32'hB11);
        repeat (3) @(negedge clk_main_a0);
        rd(32'h558, "status_ovf", d);  chk("status_ovf_lit", d, 32'h0004_100E);
        rd(32'h554, "res_full", d);    chk("res_full_lit", d, 32'hB00);
        repeat (3) @(negedge clk_main_a0);
        rd(32'h558, "status_drain", d); chk("status_drain_lit", d, 32'h0004_1006);
        wr(32'h560, 32'h1);

        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: begin
                    @(negedge clk_main_a0);
                    core_found = CORES'($urandom_range(0, (1 << CORES) - 1));
                    for (int i = 0; i < CORES; i++) core_nonce[32*i +: 32] = $urandom;
                    @(negedge clk_main_a0);
                    core_found = '0;
                    repeat ($urandom_range(0, 2)) @(negedge clk_main_a0);
                end
                4, 5: rd(32'h554, "rnd_result", d);
                6: begin
                    case ($urandom_range(0, 4))
                        0: rd(32'h558, "rnd_status", d);
                        1: rd(32'h564, "rnd_fcnt", d);
                        2: rd(32'h55C, "rnd_base", d);
                        3: rd(32'h504 + 32'(4 * $urandom_range(0, 19)), "rnd_blk", d);
                        default: rd(32'h600 + 32'(4 * $urandom_range(0, 7)), "rnd_unmapped", d);
                    endcase
                end
                7: wr(32'h55C, $urandom);
                8: wr(32'h504 + 32'(4 * $urandom_range(0, 18)), $urandom);
                default: begin
                    if ($urandom_range(0, 3) == 0) begin
                        if ($urandom_range(0, 1) == 1) wr(32'h550, $urandom);
                        else wr(32'h560, 32'h1);
                    end else rd(32'h558, "rnd_status2", d);
                end
            endcase
        end

        @(negedge clk_main_a0);
        awvalid = 1; awaddr = 32'h55C;
        @(posedge clk_main_a0);
        @(negedge clk_main_a0);
        awvalid = 0;
        chk("midwr_awready_busy", 32'(awready), 32'h0);
        rst_main = 1;
        #1;
        chk("midwr_awready_rst", 32'(awready), 32'h1);
        chk("midwr_bvalid_rst", 32'(bvalid), 32'h0);
        @(negedge clk_main_a0);
        rst_main = 0;
        wr(32'h55C, 32'h1234_5678);
        rd(32'h55C, "post_rst_base", d); chk("post_rst_base_lit", d, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
